fpu_share_arbiter: RTL and testbench
====================================

# fpu_share_arbiter

Round-robin arbiter that shares one pipelined single-precision FPU (add/sub, `calc_mode`, `round_mode`) between `NUM_REQ` requesters. It sits between the requester ports and the FPU instance. It accepts at most one operation per cycle and registers the operands onto the FPU inputs. A tag pipeline matched to the FPU latency tracks each operation, so every result is returned to the requester that issued it.

## Interface
- `NUM_REQ`, default 4, number of requesters (2..8).
- `FPU_LATENCY`, default 4, clock edges from the FPU input registers changing to a valid `FP_result` (1..16).
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NUM_REQ  per-requester operation request.
- `req_ready`  out  NUM_REQ  one-hot grant; accept when `req_valid[i] & req_ready[i]`.
- `req_in1`, `req_in2`  in  32*NUM_REQ  flattened operands, requester i at bits [32i+31:32i].
- `req_mode`  in  NUM_REQ  per-requester calc_mode (0 add, 1 sub).
- `req_rm`  in  2*NUM_REQ  per-requester round_mode.
- `fpu_in1`, `fpu_in2`  out  32  registered operands to FPU `FP_in1`/`FP_in2`.
- `fpu_mode`  out  1  registered to FPU `calc_mode`.
- `fpu_rm`  out  2  registered to FPU `round_mode`.
- `fpu_result`  in  32  FPU `FP_result`.
- `res_valid`  out  NUM_REQ  one-hot, one-cycle pulse: result for requester i.
- `res_data`  out  32  shared result bus, valid while any `res_valid` bit is high.
- `busy`  out  1  high while any tag is in flight.

## Operation
- Arbitration is round-robin. The search starts at `last_grant+1` modulo NUM_REQ; the first requester with `req_valid` high is granted.
- `req_ready` is combinational from `req_valid` and the pointer. At most one bit is set. Ready never depends on downstream state, because results have no backpressure.
- On accept at edge k:
  - `fpu_in1`/`fpu_in2`/`fpu_mode`/`fpu_rm` load the granted requester's fields.
  - Tag {valid=1, id} enters stage 0 of the tag pipe.
  - `last_grant` updates to the granted index.
- No accept in a cycle:
  - FPU input registers hold their previous value (no toggling).
  - A bubble tag {valid=0} enters the pipe.
  - `last_grant` is unchanged.
- The tag pipe is FPU_LATENCY stages deep and shifts every cycle. When the tag in the final stage is valid, `res_valid[id]` and `res_data` are registered from `fpu_result`.
- `busy` = OR of all tag valid bits plus the output-stage valid.
- The result order equals the accept order; there is no reordering.
- Requester i may hold `req_valid` high across consecutive cycles. Each accepted cycle is a distinct operation.

## Timing
- Reset values: `req_ready`=0, `fpu_in1`=`fpu_in2`=0, `fpu_mode`=0, `fpu_rm`=0, `res_valid`=0, `res_data`=0, `busy`=0, `last_grant`=NUM_REQ-1 (requester 0 wins first), all tags invalid.
- Reset mid-operation clears all in-flight tags immediately. Their results are never reported, even after reset is released.
- Latency: accept at edge k → `res_valid` high for the cycle after edge k+FPU_LATENCY+1.
- Throughput: one operation per cycle sustained.
- If a single requester is the only one valid, it is granted every cycle.
- If all requesters are valid, grants rotate 0,1,2,3,0,…
- An accept and a result emerging in the same cycle are independent and both take effect.
- `req_ready` is asserted in a cycle only if the selected `req_valid` is high in that cycle.

## Configuration
- Macro: `FPU_ARB_GRANT_CNT_EN`.
- When defined:
  - Adds output `grant_cnt` (16*NUM_REQ): per-requester saturating count of accepted operations.
  - Counters reset to 0 and stick at 16'hFFFF.
- When undefined:
  - The port and counters are absent.
  - All other behaviour is identical.

## Test plan
- Reset release, requester 0 only, in1=32'h3f800000, in2=32'h40000000, mode=0, rm=0 → `req_ready[0]` in the same cycle; `res_valid[0]` FPU_LATENCY+1 cycles later with `res_data`=32'h40400000; `busy` drops the next cycle.
- All 4 requesters valid for 8 cycles, each with distinct operands (r1: 40a00000−40200000) → grants 0,1,2,3,0,1,2,3; results return in the same order; r1's results = 32'h40200000.
- Requester 2 valid every cycle for 10 cycles, others idle → 10 back-to-back accepts, 10 consecutive `res_valid[2]` pulses, no bubbles.
- Requester 3 granted, then requesters 0 and 3 valid together → next grant goes to 0 (wrap-around), then 3.
- Three operations in flight, `reset` pulsed low for 1 cycle → `res_valid` stays 0 for 2*FPU_LATENCY cycles; `busy`=0; the next grant goes to requester 0.
- With `FPU_ARB_GRANT_CNT_EN`: 70000 accepts on requester 1 → `grant_cnt[1]`=16'hFFFF; other counters = 0.

Source files
------------

// File: rtl/fpu_share_arbiter.sv
// Round-robin share of one pipelined FPU among NUM_REQ requesters; accept-to-res_valid = FPU_LATENCY+1 edges, no result backpressure.
// Optional per-requester saturating accept counters on grant_cnt when FPU_ARB_GRANT_CNT_EN is defined.
module fpu_share_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int FPU_LATENCY = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [32*NUM_REQ-1:0]  req_in1,
  input  logic [32*NUM_REQ-1:0]  req_in2,
  input  logic [NUM_REQ-1:0]     req_mode,
  input  logic [2*NUM_REQ-1:0]   req_rm,
  output logic [31:0]            fpu_in1,
  output logic [31:0]            fpu_in2,
  output logic                   fpu_mode,
  output logic [1:0]             fpu_rm,
  input  logic [31:0]            fpu_result,
  output logic [NUM_REQ-1:0]     res_valid,
  output logic [31:0]            res_data,
`ifdef FPU_ARB_GRANT_CNT_EN
  output logic [16*NUM_REQ-1:0]  grant_cnt,
`endif
  output logic                   busy
);

  localparam int IDW = $clog2(NUM_REQ);

  typedef struct packed {
    logic           vld;
    logic [IDW-1:0] id;
  } tag_t;

  logic [IDW-1:0] last_grant;
  logic [IDW-1:0] grant_id;
  logic           grant_vld;
  logic           accept;

  // Stage 0 is aligned with the FPU input registers; the last stage lines up with a valid fpu_result.
  tag_t tag_pipe [FPU_LATENCY+1];

  always_comb begin
    grant_vld = 1'b0;
    grant_id  = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      int cand;
      cand = (int'(last_grant) + off) % NUM_REQ;
      if (!grant_vld && req_valid[cand]) begin
        grant_vld = 1'b1;
        grant_id  = IDW'(cand);
      end
    end
  end

  assign accept = grant_vld & reset;

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[grant_id] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fpu_in1    <= '0;
      fpu_in2    <= '0;
      fpu_mode   <= 1'b0;
      fpu_rm     <= '0;
      last_grant <= IDW'(NUM_REQ - 1);
    end else if (accept) begin
      fpu_in1    <= req_in1[32*int'(grant_id) +: 32];
      fpu_in2    <= req_in2[32*int'(grant_id) +: 32];
      fpu_mode   <= req_mode[grant_id];
      fpu_rm     <= req_rm[2*int'(grant_id) +: 2];
      last_grant <= grant_id;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i <= FPU_LATENCY; i++) tag_pipe[i] <= '0;
      res_valid <= '0;
      res_data  <= '0;
    end else begin
      tag_pipe[0] <= '{vld: accept, id: grant_id};
      for (int i = 1; i <= FPU_LATENCY; i++) tag_pipe[i] <= tag_pipe[i-1];
      res_valid <= '0;
      if (tag_pipe[FPU_LATENCY].vld) begin
        res_valid[tag_pipe[FPU_LATENCY].id] <= 1'b1;
        res_data                            <= fpu_result;
      end
    end
  end

  always_comb begin
    busy = |res_valid;
    for (int i = 0; i <= FPU_LATENCY; i++) busy = busy | tag_pipe[i].vld;
  end

`ifdef FPU_ARB_GRANT_CNT_EN
  logic [15:0] cnt [NUM_REQ];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REQ; i++) cnt[i] <= '0;
    end else if (accept && cnt[grant_id] != 16'hFFFF) begin
      cnt[grant_id] <= cnt[grant_id] + 16'd1;
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt
    assign grant_cnt[16*g +: 16] = cnt[g];
  end
`endif

endmodule

// File: tb/tb_fpu_share_arbiter.sv
// Bench for fpu_share_arbiter: behavioural FPU plus a queue-based arbiter model checked every cycle.
module tb_fpu_share_arbiter;
  localparam int N = 4;
  localparam int L = 4;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [32*N-1:0] req_in1, req_in2;
  logic [N-1:0]    req_mode;
  logic [2*N-1:0]  req_rm;
  logic [31:0]     fpu_in1, fpu_in2, fpu_result, res_data;
  logic            fpu_mode, busy;
  logic [1:0]      fpu_rm;
  logic [N-1:0]    res_valid;
`ifdef FPU_ARB_GRANT_CNT_EN
  logic [16*N-1:0] grant_cnt;
`endif

  fpu_share_arbiter #(.NUM_REQ(N), .FPU_LATENCY(L)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_in1(req_in1), .req_in2(req_in2), .req_mode(req_mode), .req_rm(req_rm),
    .fpu_in1(fpu_in1), .fpu_in2(fpu_in2), .fpu_mode(fpu_mode), .fpu_rm(fpu_rm),
    .fpu_result(fpu_result),
    .res_valid(res_valid), .res_data(res_data),
`ifdef FPU_ARB_GRANT_CNT_EN
    .grant_cnt(grant_cnt),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Exact single-precision add/sub for normal operands (no rounding needed for the vectors used).
  function automatic logic [31:0] fp_addsub(input logic [31:0] a, input logic [31:0] b, input logic sub);
    logic sa, sb, st;
    int ea, eb, er;
    logic [41:0] ma, mb, mr;
    logic [31:0] t;
    sa = a[31];
    sb = b[31] ^ sub;
    if (a[30:0] == 0) return {sb, b[30:0]};
    if (b[30:0] == 0) return a;
    if (b[30:0] > a[30:0]) begin
      st = sa; sa = sb; sb = st;
      t = a; a = b; b = t;
    end
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    ma = {2'b0, 1'b1, a[22:0], 16'b0};
    mb = {2'b0, 1'b1, b[22:0], 16'b0} >> (ea - eb);
    mr = (sa == sb) ? ma + mb : ma - mb;
    er = ea;
    if (mr == 0) return 32'h0;
    if (mr[40]) begin
      mr = mr >> 1;
      er++;
    end
    for (int i = 0; i < 40; i++) begin
      if (!mr[39]) begin
        mr = mr << 1;
        er--;
      end
    end
    return {sa, er[7:0], mr[38:16]};
  endfunction

  // Behavioural FPU: result valid L edges after its inputs change.
  logic [31:0] fpu_pipe [L];
  initial for (int i = 0; i < L; i++) fpu_pipe[i] = '0;
  always @(posedge clk) begin
    fpu_pipe[0] <= fp_addsub(fpu_in1, fpu_in2, fpu_mode);
    for (int i = 1; i < L; i++) fpu_pipe[i] <= fpu_pipe[i-1];
  end
  assign fpu_result = fpu_pipe[L-1];

  typedef struct {
    int          id;
    logic [31:0] data;
    int          due;
  } op_t;

  typedef struct {
    int          id;
    logic [31:0] data;
    int          edge_n;
  } res_t;

  op_t   q[$];
  res_t  res_log[$];
  int    grant_log[$];
  int    grant_edge[$];
  int    edge_cnt = 0;
  int    ptr = N - 1;
  logic [31:0] e_in1 = '0, e_in2 = '0;
  logic        e_mode = 1'b0;
  logic [1:0]  e_rm = '0;

  always @(posedge clk) edge_cnt++;

  always @(negedge clk) begin
    if (!reset) begin
      q.delete();
      ptr = N - 1;
      e_in1 = '0; e_in2 = '0; e_mode = 1'b0; e_rm = '0;
      chk("rst_ready", 32'(req_ready), 32'h0);
      chk("rst_res_valid", 32'(res_valid), 32'h0);
      chk("rst_res_data", res_data, 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_fpu_in1", fpu_in1, 32'h0);
    end else begin
      int gid;
      logic [N-1:0] exp_rdy, exp_rv;
      logic [31:0]  exp_dat;
      gid = -1;
      for (int off = 1; off <= N; off++)
        if (gid < 0 && req_valid[(ptr + off) % N]) gid = (ptr + off) % N;
      exp_rdy = '0;
      if (gid >= 0) exp_rdy[gid] = 1'b1;
      chk("req_ready", 32'(req_ready), 32'(exp_rdy));
      chk("fpu_in1", fpu_in1, e_in1);
      chk("fpu_in2", fpu_in2, e_in2);
      chk("fpu_mode_rm", {29'b0, fpu_mode, fpu_rm}, {29'b0, e_mode, e_rm});
      chk("busy", 32'(busy), 32'(q.size() != 0));
      exp_rv = '0;
      exp_dat = '0;
      if (q.size() != 0 && q[0].due == edge_cnt) begin
        exp_rv[q[0].id] = 1'b1;
        exp_dat = q[0].data;
        void'(q.pop_front());
      end
      chk("res_valid", 32'(res_valid), 32'(exp_rv));
      if (exp_rv != 0) chk("res_data", res_data, exp_dat);
      for (int i = 0; i < N; i++) begin
        if (req_ready[i]) begin
          grant_log.push_back(i);
          grant_edge.push_back(edge_cnt);
        end
        if (res_valid[i]) res_log.push_back('{i, res_data, edge_cnt});
      end
      if (gid >= 0) begin
        e_in1  = req_in1[32*gid +: 32];
        e_in2  = req_in2[32*gid +: 32];
        e_mode = req_mode[gid];
        e_rm   = req_rm[2*gid +: 2];
        q.push_back('{gid, fp_addsub(e_in1, e_in2, e_mode), edge_cnt + L + 2});
        ptr = gid;
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    wait_cyc(1);
    req_valid = '0;
    reset = 1'b0;
    wait_cyc(2);
    reset = 1'b1;
    grant_log.delete();
    grant_edge.delete();
    res_log.delete();
  endtask

  initial begin
    // r0: 1+2, r1: 5-2.5, r2: 3+4, r3: 8-1; round mode = index
    req_in1  = {32'h41000000, 32'h40400000, 32'h40a00000, 32'h3f800000};
    req_in2  = {32'h3f800000, 32'h40800000, 32'h40200000, 32'h40000000};
    req_mode = 4'b1010;
    req_rm   = {2'd3, 2'd2, 2'd1, 2'd0};

    // single op on requester 0
    do_reset();
    req_valid = 4'b0001;
    wait_cyc(1);
    req_valid = '0;
    wait_cyc(L + 5);
    chk("t1_ngrant", grant_log.size(), 1);
    chk("t1_nres", res_log.size(), 1);
    if (grant_log.size() == 1 && res_log.size() == 1) begin
      chk("t1_grant", grant_log[0], 0);
      chk("t1_res_id", res_log[0].id, 0);
      chk("t1_res_data", res_log[0].data, 32'h40400000);
      chk("t1_latency", res_log[0].edge_n - grant_edge[0], 6);
    end

    // all four requesters for 8 cycles
    do_reset();
    req_valid = 4'b1111;
    wait_cyc(8);
    req_valid = '0;
    wait_cyc(L + 5);
    chk("t2_ngrant", grant_log.size(), 8);
    chk("t2_nres", res_log.size(), 8);
    if (grant_log.size() == 8 && res_log.size() == 8) begin
      for (int i = 0; i < 8; i++) begin
        chk("t2_grant", grant_log[i], i % 4);
        chk("t2_res_id", res_log[i].id, i % 4);
      end
      chk("t2_r1_data_a", res_log[1].data, 32'h40200000);
      chk("t2_r1_data_b", res_log[5].data, 32'h40200000);
      chk("t2_r2_data", res_log[2].data, 32'h40e00000);
      chk("t2_r3_data", res_log[3].data, 32'h40e00000);
    end

    // requester 2 alone, back to back
    do_reset();
    req_valid = 4'b0100;
    wait_cyc(10);
    req_valid = '0;
    wait_cyc(L + 5);
    chk("t3_ngrant", grant_log.size(), 10);
    chk("t3_nres", res_log.size(), 10);
    if (res_log.size() == 10 && grant_log.size() == 10) begin
      for (int i = 0; i < 10; i++) begin
        chk("t3_grant", grant_log[i], 2);
        chk("t3_res_gap", res_log[i].edge_n - res_log[0].edge_n, i);
      end
    end

    // wrap-around: 3 first, then 0 and 3 together
    do_reset();
    req_valid = 4'b1000;
    wait_cyc(1);
    req_valid = 4'b1001;
    wait_cyc(2);
    req_valid = '0;
    wait_cyc(L + 5);
    chk("t4_ngrant", grant_log.size(), 3);
    if (grant_log.size() == 3) begin
      chk("t4_g0", grant_log[0], 3);
      chk("t4_g1", grant_log[1], 0);
      chk("t4_g2", grant_log[2], 3);
    end

    // reset with three ops in flight
    do_reset();
    req_valid = 4'b1111;
    wait_cyc(3);
    req_valid = '0;
    reset = 1'b0;
    wait_cyc(1);
    reset = 1'b1;
    wait_cyc(2 * L);
    chk("t5_nres", res_log.size(), 0);
    chk("t5_busy", 32'(busy), 32'h0);
    grant_log.delete();
    req_valid = 4'b1111;
    wait_cyc(1);
    req_valid = '0;
    wait_cyc(L + 5);
    chk("t5_ngrant", grant_log.size(), 1);
    if (grant_log.size() == 1) chk("t5_grant", grant_log[0], 0);

`ifdef FPU_ARB_GRANT_CNT_EN
    do_reset();
    req_valid = 4'b0010;
    wait_cyc(70000);
    req_valid = '0;
    wait_cyc(L + 5);
    chk("cnt_r1", grant_cnt[31:16], 32'hFFFF);
    chk("cnt_r0", grant_cnt[15:0], 32'h0);
    chk("cnt_r2", grant_cnt[47:32], 32'h0);
    chk("cnt_r3", grant_cnt[63:48], 32'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
